bitmanip_issue: RTL and testbench
=================================

Name: bitmanip_issue

Overview:
Decode/issue stage directly upstream of the bitmanip execute unit. It accepts RV32 instruction words with operands over a valid/ready handshake and decodes the Zb* subset into the 22-bit one-hot control vector the execute unit consumes: imm in [21:16], op flags in [15:0]. It buffers one extra entry (skid) to sustain full throughput. It stalls back-to-back carry-less multiplies while the iterative clmul unit is still busy.

Parameters:
CLMUL_LAT, 4, cycles the execute clmul unit is occupied per clmul/clmulh; legal range 1..15; 1 means no stall.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_instr  in  32  RV32 instruction word
in_rs1  in  32  source operand 1
in_rs2  in  32  source operand 2
out_valid  out  1  entry presented to execute
out_ready  in  1  execute accepts entry
out_ctrl  out  22  {imm[5:0], clmul, clmulh, xperm_n, xperm_b, ror, rol, rori, andn, orn, xnor, pack, packu, packh, grevi, shfl, unshfl}
out_rs1  out  32  registered rs1
out_rs2  out  32  registered rs2
out_rd_addr  out  5  in_instr[11:7], registered
out_illegal  out  1  entry matched no supported op; out_ctrl is 0

Behaviour:
- Decode is combinational on in_instr. Fields used: f7=[31:25], f3=[14:12], opc=[6:0].
- OP (0110011) encodings:
  - clmul 0000101/001; clmulh 0000101/011
  - xperm.n 0010100/010; xperm.b 0010100/100
  - ror 0110000/101; rol 0110000/001
  - andn 0100000/111; orn 0100000/110; xnor 0100000/100
  - pack 0000100/100; packu 0100100/100; packh 0000100/111
  - shfl 0000100/001; unshfl 0000100/101
- OP-IMM (0010011) encodings: rori f7=0110000/101; grevi f7=0110100/101.
- imm field = {1'b0, in_instr[24:20]} for rori/grevi; 0 otherwise.
- Anything else: ctrl=0, illegal=1. Illegal entries still flow in order.
- Exactly one op bit is set for a legal entry.
- Storage: main register (drives outputs) plus one skid register. Each entry = {ctrl, illegal, rs1, rs2, rd_addr}.
- in_ready is registered; it is 1 iff the skid register is empty. No combinational path exists from out_ready to in_ready.
- Input transfer happens on in_valid & in_ready. Output transfer happens on out_valid & out_ready.
- Accepted entry placement:
  - Goes to main if main is empty or main transfers this cycle, provided skid is empty.
  - Otherwise it goes to skid.
  - Skid moves to main when main transfers.
- Strict FIFO order is kept. Latency is 1 cycle from acceptance to out_valid when empty and no hazard.
- Simultaneous input and output transfer with skid empty: main reloads, throughput is 1/cycle.
- Hazard counter clmul_cnt (4 bits):
  - Loads CLMUL_LAT-1 on an output transfer with ctrl[15]|ctrl[14]; otherwise decrements, saturating at 0.
  - out_valid = main_valid & ~((ctrl[15]|ctrl[14]) & clmul_cnt!=0).
  - Non-clmul entries are never stalled by the counter.
- Outputs change only on clk. Once out_valid=1 it stays asserted with stable data until transferred.
- Reset (rst=0, asynchronous), values hold while asserted:
  - out_valid=0, in_ready=1, clmul_cnt=0
  - out_ctrl=0, out_illegal=0, out_rs1=0, out_rs2=0, out_rd_addr=0
  - both entries invalid
- Reset mid-operation discards buffered entries, including a stalled clmul, with no output transfer.

Test Plan:
- andn: in_instr=0x4020F1B3, rs1=0xF0F0F0F0, rs2=0xFF00FF00, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x000100, out_rd_addr=3, out_rs1/out_rs2 unchanged, out_illegal=0.
- rori: in_instr=0x60735293 -> out_ctrl=0x070200, out_rd_addr=5. Illegal: in_instr=0x00000013 -> out_illegal=1, out_ctrl=0.
- Streaming and backpressure:
  - Stream 8 mixed legal ops with in_valid=1, out_ready=1 -> one transfer per cycle, order preserved.
  - Drop out_ready for 3 cycles -> in_ready=0 one cycle after the skid fills.
  - No entry is lost or duplicated on out_ready re-assert.
- Clmul hazard, CLMUL_LAT=4: clmul 0x0A3110B3 twice back-to-back -> first transfers at cycle t; second has out_valid=0 for cycles t+1..t+3 and transfers at t+4.
- Hazard does not block other ops: clmul, then andn -> andn transfers at t+1.
- Reset: assert rst=0 with both entries full and a stalled clmul -> out_valid=0, in_ready=1 immediately. After release, the first new entry appears after 1 cycle with no stall.

Source files
------------

// File: rtl/bitmanip_issue.sv
// Decode/issue stage for the bitmanip execute unit.
// Decodes the supported Zb* ops into a one-hot control vector and holds up to two entries
// (main + skid). A clmul/clmulh at the head is held back while the iterative clmul unit
// is still busy with the previous one.
module bitmanip_issue #(
    parameter int unsigned CLMUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [21:0] out_ctrl,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic [4:0]  out_rd_addr,
    output logic        out_illegal
);

    // Major opcodes
    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    // Op flag positions inside out_ctrl[15:0]
    localparam int unsigned BitClmul  = 15;
    localparam int unsigned BitClmulh = 14;
    localparam int unsigned BitXpermN = 13;
    localparam int unsigned BitXpermB = 12;
    localparam int unsigned BitRor    = 11;
    localparam int unsigned BitRol    = 10;
    localparam int unsigned BitRori   = 9;
    localparam int unsigned BitAndn   = 8;
    localparam int unsigned BitOrn    = 7;
    localparam int unsigned BitXnor   = 6;
    localparam int unsigned BitPack   = 5;
    localparam int unsigned BitPacku  = 4;
    localparam int unsigned BitPackh  = 3;
    localparam int unsigned BitGrevi  = 2;
    localparam int unsigned BitShfl   = 1;
    localparam int unsigned BitUnshfl = 0;

    // Value the busy counter takes when a clmul leaves; 0 means back-to-back is allowed.
    localparam logic [3:0] ClmulLoad = 4'(CLMUL_LAT - 1);

    typedef struct packed {
        logic [21:0] ctrl;
        logic        illegal;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd_addr;
    } entry_t;

    localparam entry_t EntryReset = '0;

    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [9:0]  funct;
    logic [15:0] dec_op;
    logic [5:0]  dec_imm;
    entry_t      dec_entry;

    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic [3:0]  clmul_cnt_q, clmul_cnt_d;

    logic        main_is_clmul;
    logic        in_xfer;
    logic        out_xfer;

    // rs1 register field is not needed here; operands arrive pre-read.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^in_instr[19:15];

    assign f7    = in_instr[31:25];
    assign f3    = in_instr[14:12];
    assign opc   = in_instr[6:0];
    assign funct = {f7, f3};

    // Combinational decode of the incoming word into op flags and shift immediate
    always_comb begin
        dec_op  = '0;
        dec_imm = '0;
        if (opc == OpcOp) begin
            case (funct)
                {7'b0000101, 3'b001}: dec_op[BitClmul]  = 1'b1;
                {7'b0000101, 3'b011}: dec_op[BitClmulh] = 1'b1;
                {7'b0010100, 3'b010}: dec_op[BitXpermN] = 1'b1;
                {7'b0010100, 3'b100}: dec_op[BitXpermB] = 1'b1;
                {7'b0110000, 3'b101}: dec_op[BitRor]    = 1'b1;
                {7'b0110000, 3'b001}: dec_op[BitRol]    = 1'b1;
                {7'b0100000, 3'b111}: dec_op[BitAndn]   = 1'b1;
                {7'b0100000, 3'b110}: dec_op[BitOrn]    = 1'b1;
                {7'b0100000, 3'b100}: dec_op[BitXnor]   = 1'b1;
                {7'b0000100, 3'b100}: dec_op[BitPack]   = 1'b1;
                {7'b0100100, 3'b100}: dec_op[BitPacku]  = 1'b1;
                {7'b0000100, 3'b111}: dec_op[BitPackh]  = 1'b1;
                {7'b0000100, 3'b001}: dec_op[BitShfl]   = 1'b1;
                {7'b0000100, 3'b101}: dec_op[BitUnshfl] = 1'b1;
                default: ;
            endcase
        end else if (opc == OpcOpImm) begin
            case (funct)
                {7'b0110000, 3'b101}: begin
                    dec_op[BitRori] = 1'b1;
                    dec_imm         = {1'b0, in_instr[24:20]};
                end
                {7'b0110100, 3'b101}: begin
                    dec_op[BitGrevi] = 1'b1;
                    dec_imm          = {1'b0, in_instr[24:20]};
                end
                default: ;
            endcase
        end
    end

    // Pack the decoded word with its operands into one buffer entry
    always_comb begin
        dec_entry         = EntryReset;
        dec_entry.ctrl    = {dec_imm, dec_op};
        dec_entry.illegal = (dec_op == '0);
        dec_entry.rs1     = in_rs1;
        dec_entry.rs2     = in_rs2;
        dec_entry.rd_addr = in_instr[11:7];
    end

    assign main_is_clmul = main_q.ctrl[BitClmul] | main_q.ctrl[BitClmulh];

    // Hold a clmul at the head while the previous one still occupies the unit.
    assign out_valid = main_valid_q & ~(main_is_clmul & (clmul_cnt_q != 4'd0));
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Next-state for the main/skid pair; skid can only hold data while main is full
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_xfer) begin
            if (skid_valid_q) begin
                // in_ready was low, so nothing new arrives this cycle
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d = dec_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid_q) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec_entry;
                skid_valid_d = 1'b1;
            end
        end
        // Registered ready: depends only on next skid occupancy, never on out_ready directly
        in_ready_d = ~skid_valid_d;
    end

    // Busy counter for the iterative clmul unit: reload on clmul issue, else count down to 0
    always_comb begin
        clmul_cnt_d = clmul_cnt_q;
        if (out_xfer && main_is_clmul) begin
            clmul_cnt_d = ClmulLoad;
        end else if (clmul_cnt_q != 4'd0) begin
            clmul_cnt_d = clmul_cnt_q - 4'd1;
        end
    end

    // State registers; reset discards both entries and clears the hazard counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q       <= EntryReset;
            skid_q       <= EntryReset;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            clmul_cnt_q  <= 4'd0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            clmul_cnt_q  <= clmul_cnt_d;
        end
    end

    assign out_ctrl    = main_q.ctrl;
    assign out_illegal = main_q.illegal;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd_addr = main_q.rd_addr;

endmodule

// File: tb/tb_bitmanip_issue.sv
// Self-checking bench for bitmanip_issue: directed scenarios plus randomized traffic
// compared against a transaction-level queue model.
module tb_bitmanip_issue;

    localparam int unsigned ClmulLat = 4;
    localparam logic [6:0]  OpcOp    = 7'b0110011;
    localparam logic [6:0]  OpcOpImm = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [21:0] out_ctrl;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd_addr;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    bitmanip_issue #(.CLMUL_LAT(ClmulLat)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd_addr(out_rd_addr),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Encodings listed in out_ctrl order: entry i drives op bit 15-i. {opc, f7, f3}
    logic [16:0] enc_tab [16];

    typedef struct {
        logic [21:0] ctrl;
        logic        illegal;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        bit          is_clmul;
    } exp_t;

    exp_t mq[$];
    int   cyc = 0;
    int   last_clmul = -1000;

    task automatic init_table();
        enc_tab[0]  = {OpcOp,    7'b0000101, 3'b001}; // clmul
        enc_tab[1]  = {OpcOp,    7'b0000101, 3'b011}; // clmulh
        enc_tab[2]  = {OpcOp,    7'b0010100, 3'b010}; // xperm.n
        enc_tab[3]  = {OpcOp,    7'b0010100, 3'b100}; // xperm.b
        enc_tab[4]  = {OpcOp,    7'b0110000, 3'b101}; // ror
        enc_tab[5]  = {OpcOp,    7'b0110000, 3'b001}; // rol
        enc_tab[6]  = {OpcOpImm, 7'b0110000, 3'b101}; // rori
        enc_tab[7]  = {OpcOp,    7'b0100000, 3'b111}; // andn
        enc_tab[8]  = {OpcOp,    7'b0100000, 3'b110}; // orn
        enc_tab[9]  = {OpcOp,    7'b0100000, 3'b100}; // xnor
        enc_tab[10] = {OpcOp,    7'b0000100, 3'b100}; // pack
        enc_tab[11] = {OpcOp,    7'b0100100, 3'b100}; // packu
        enc_tab[12] = {OpcOp,    7'b0000100, 3'b111}; // packh
        enc_tab[13] = {OpcOpImm, 7'b0110100, 3'b101}; // grevi
        enc_tab[14] = {OpcOp,    7'b0000100, 3'b001}; // shfl
        enc_tab[15] = {OpcOp,    7'b0000100, 3'b101}; // unshfl
    endtask

    function automatic exp_t make_entry(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2);
        exp_t e;
        e.ctrl    = '0;
        e.illegal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ({instr[6:0], instr[31:25], instr[14:12]} == enc_tab[i]) begin
                e.ctrl[15 - i] = 1'b1;
                e.illegal      = 1'b0;
                if (i == 6 || i == 13) e.ctrl[21:16] = {1'b0, instr[24:20]};
            end
        end
        e.rs1      = rs1;
        e.rs2      = rs2;
        e.rd       = instr[11:7];
        e.is_clmul = (e.ctrl[15] | e.ctrl[14]);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr(bit allow_clmul, bit allow_illegal);
        int          k;
        logic [16:0] e;
        if (allow_illegal && $urandom_range(0, 5) == 0) return $urandom();
        do k = $urandom_range(0, 15); while (!allow_clmul && k < 2);
        e = enc_tab[k];
        return {e[9:3], 5'($urandom), 5'($urandom), e[2:0], 5'($urandom), e[16:10]};
    endfunction

    // A clmul may leave at edge n only if the previous one left at edge <= n - ClmulLat.
    function automatic logic model_out_valid();
        if (mq.size() == 0) return 1'b0;
        if (mq[0].is_clmul && (cyc - last_clmul) < int'(ClmulLat)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_in_ready();
        return (mq.size() < 2);
    endfunction

    task automatic model_update();
        logic ov;
        logic ir;
        if (!rst) begin
            mq.delete();
            last_clmul = -1000;
        end else begin
            ov = model_out_valid();
            ir = model_in_ready();
            if (ov && out_ready) begin
                if (mq[0].is_clmul) last_clmul = cyc;
                void'(mq.pop_front());
            end
            if (in_valid && ir) mq.push_back(make_entry(in_instr, in_rs1, in_rs2));
        end
        cyc++;
    endtask

    // Advance one clock: model follows the upcoming edge, returns at the next negedge.
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_handshake: got v/r=%b expected 01", {out_valid, in_ready});
        end
        n_checks++;
        if ({out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: ctrl=%h ill=%b rs1=%h rs2=%h rd=%0d expected all 0",
                     out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr);
        end
        rst = 1'b1;
        mq.delete();
        last_clmul = -1000;
        tick();
    endtask

    task automatic test_andn();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h4020F1B3;
        in_rs1    = 32'hF0F0F0F0;
        in_rs2    = 32'hFF00FF00;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_ctrl, out_illegal, out_rd_addr} !== {1'b1, 22'h000100, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL andn_ctrl: got v=%b ctrl=%h ill=%b rd=%0d expected 1 000100 0 3",
                     out_valid, out_ctrl, out_illegal, out_rd_addr);
        end
        n_checks++;
        if ({out_rs1, out_rs2} !== {32'hF0F0F0F0, 32'hFF00FF00}) begin
            n_fail++;
            $display("FAIL andn_operands: got %h %h expected f0f0f0f0 ff00ff00", out_rs1, out_rs2);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL andn_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rori_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h60735293;
        in_rs1    = 32'h12345678;
        in_rs2    = 32'h0;
        tick();
        in_instr = 32'h00000013;
        n_checks++;
        if ({out_valid, out_ctrl, out_illegal, out_rd_addr} !== {1'b1, 22'h070200, 1'b0, 5'd5}) begin
            n_fail++;
            $display("FAIL rori_ctrl: got v=%b ctrl=%h ill=%b rd=%0d expected 1 070200 0 5",
                     out_valid, out_ctrl, out_illegal, out_rd_addr);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_ctrl, out_illegal} !== {1'b1, 22'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_entry: got v=%b ctrl=%h ill=%b expected 1 000000 1",
                     out_valid, out_ctrl, out_illegal);
        end
        tick();
    endtask

    task automatic test_stream();
        exp_t h;
        logic exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_instr = gen_instr(1'b0, 1'b0);
                in_rs1   = $urandom();
                in_rs2   = $urandom();
            end else begin
                in_valid = 1'b0;
            end
            exp_v = (c >= 1 && c <= 8);
            n_checks++;
            if ({out_valid, in_ready} !== {exp_v, 1'b1}) begin
                n_fail++;
                $display("FAIL stream_rate c=%0d: got v/r=%b%b expected %b1", c, out_valid,
                         in_ready, exp_v);
            end
            if (model_out_valid()) begin
                h = mq[0];
                n_checks++;
                if ({out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr} !==
                    {h.ctrl, h.illegal, h.rs1, h.rs2, h.rd}) begin
                    n_fail++;
                    $display("FAIL stream_data c=%0d: got %h/%b/%h/%h/%0d expected %h/%b/%h/%h/%0d",
                             c, out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr,
                             h.ctrl, h.illegal, h.rs1, h.rs2, h.rd);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        exp_t h;
        logic exp_r;
        for (int c = 0; c < 18; c++) begin
            out_ready = !(c >= 2 && c < 5);
            in_valid  = (c < 10);
            in_instr  = gen_instr(1'b0, 1'b1);
            in_rs1    = $urandom();
            in_rs2    = $urandom();
            exp_r     = !(c >= 3 && c <= 5);
            n_checks++;
            if (in_ready !== exp_r) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d: in_ready=%b expected %b", c, in_ready, exp_r);
            end
            n_checks++;
            if (out_valid !== model_out_valid()) begin
                n_fail++;
                $display("FAIL bp_valid c=%0d: out_valid=%b expected %b", c, out_valid,
                         model_out_valid());
            end
            if (model_out_valid()) begin
                h = mq[0];
                n_checks++;
                if ({out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr} !==
                    {h.ctrl, h.illegal, h.rs1, h.rs2, h.rd}) begin
                    n_fail++;
                    $display("FAIL bp_data c=%0d: got %h/%b/%h/%h/%0d expected %h/%b/%h/%h/%0d",
                             c, out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr,
                             h.ctrl, h.illegal, h.rs1, h.rs2, h.rd);
                end
            end
            tick();
        end
        n_checks++;
        if ({out_valid, in_ready, 1'(mq.size() == 0)} !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_drained: v/r=%b%b model_left=%0d expected 01 and 0", out_valid,
                     in_ready, mq.size());
        end
    endtask

    task automatic test_clmul_hazard();
        logic exp_v;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0A3110B3;
        in_rs1    = 32'h1;
        in_rs2    = 32'h2;
        tick();
        in_rs1 = 32'h3;
        in_rs2 = 32'h4;
        // c=0 is the cycle ending with the first transfer (edge t)
        for (int c = 0; c < 6; c++) begin
            exp_v = (c == 0 || c == 4);
            n_checks++;
            if ({out_valid, out_ctrl} !== {exp_v, 22'h008000}) begin
                n_fail++;
                $display("FAIL clmul_stall c=%0d: got v=%b ctrl=%h expected %b 008000", c,
                         out_valid, out_ctrl, exp_v);
            end
            tick();
            in_valid = 1'b0;
        end
        idle(4);
    endtask

    task automatic test_hazard_bypass();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0A3110B3;
        tick();
        in_instr = 32'h4020F1B3;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_ctrl} !== {1'b1, 22'h000100}) begin
            n_fail++;
            $display("FAIL bypass_andn: got v=%b ctrl=%h expected 1 000100", out_valid, out_ctrl);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_drain: out_valid=%b expected 0", out_valid);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0A3110B3;
        tick();
        tick();
        in_instr = 32'h4020F1B3;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_full: got v/r=%b%b expected 00", out_valid, in_ready);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, out_ctrl} !== {2'b01, 22'h0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got v/r=%b%b ctrl=%h expected 01 000000", out_valid,
                     in_ready, out_ctrl);
        end
        tick();
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_hold: got v/r=%b%b expected 01", out_valid, in_ready);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0A3110B3;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_ctrl, out_rd_addr} !== {1'b1, 22'h008000, 5'd1}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got v=%b ctrl=%h rd=%0d expected 1 008000 1",
                     out_valid, out_ctrl, out_rd_addr);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_once: out_valid=%b expected 0", out_valid);
        end
        idle(4);
    endtask

    task automatic test_random();
        exp_t h;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_instr = gen_instr(1'b1, 1'b1);
            in_rs1   = $urandom();
            in_rs2   = $urandom();
            n_checks++;
            if ({out_valid, in_ready} !== {model_out_valid(), model_in_ready()}) begin
                n_fail++;
                $display("FAIL rand_handshake c=%0d: got v/r=%b%b expected %b%b", c, out_valid,
                         in_ready, model_out_valid(), model_in_ready());
            end
            if (model_out_valid()) begin
                h = mq[0];
                n_checks++;
                if ({out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr} !==
                    {h.ctrl, h.illegal, h.rs1, h.rs2, h.rd}) begin
                    n_fail++;
                    $display("FAIL rand_data c=%0d: got %h/%b/%h/%h/%0d expected %h/%b/%h/%h/%0d",
                             c, out_ctrl, out_illegal, out_rs1, out_rs2, out_rd_addr,
                             h.ctrl, h.illegal, h.rs1, h.rs2, h.rd);
                end
            end
            tick();
        end
        n_checks++;
        if ({out_valid, 1'(mq.size() == 0)} !== 2'b01) begin
            n_fail++;
            $display("FAIL rand_drained: out_valid=%b model_left=%0d expected 0 and 0", out_valid,
                     mq.size());
        end
    endtask

    initial begin
        init_table();
        repeat (2) @(negedge clk);
        test_reset();
        test_andn();
        test_rori_illegal();
        test_stream();
        test_backpressure();
        test_clmul_hazard();
        test_hazard_bypass();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
